// File: rtl/rand_word_arb.sv
// rand_word_arb: two-requester round-robin arbiter that assembles a WIDTH-bit random word
// from a serial bit source and hands it to the granted requester.
// Define RAND_LFSR_EN to use an internal 16-bit Galois LFSR instead of RAND_IN.
module rand_word_arb #(
    parameter int          WIDTH = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RAND_IN,
    output logic             RAND_EN,
    input  logic [1:0]       REQ,
    output logic [1:0]       GNT,
    output logic [1:0]       VALID,
    input  logic [1:0]       ACK,
    output logic [WIDTH-1:0] DATA,
    output logic             BUSY
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t           state, state_n;
    logic [1:0]       gnt_n;
    logic             last, last_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] word, word_n;
    logic             bit_in;

`ifdef RAND_LFSR_EN
    logic [15:0] lfsr;
    logic        unused_rand_in;
    assign unused_rand_in = RAND_IN;
    assign bit_in = lfsr[0];
    // Galois LFSR advances only on cycles where a bit is consumed; a zero seed would lock up
    always_ff @(posedge CLK) begin
        if (RESET)
            lfsr <= (SEED == 16'h0000) ? 16'h0001 : SEED;
        else if (RAND_EN)
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
`else
    logic unused_seed;
    assign unused_seed = ^SEED;
    assign bit_in = RAND_IN;
`endif

    // state, grant, round-robin pointer, counter and shift register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            GNT   <= 2'b00;
            last  <= 1'b1;
            cnt   <= '0;
            word  <= '0;
        end else begin
            state <= state_n;
            GNT   <= gnt_n;
            last  <= last_n;
            cnt   <= cnt_n;
            word  <= word_n;
        end
    end

    // next state: arbitrate in IDLE, shift bits in COLLECT, wait for the owner's ACK in DONE
    always_comb begin
        state_n = state;
        gnt_n   = GNT;
        last_n  = last;
        cnt_n   = cnt;
        word_n  = word;
        case (state)
            IDLE: begin
                if (|REQ) begin
                    state_n = COLLECT;
                    gnt_n   = (REQ == 2'b11) ? (last ? 2'b01 : 2'b10) : REQ;
                    cnt_n   = '0;
                    word_n  = '0;
                end
            end
            COLLECT: begin
                if (~|(REQ & GNT)) begin
                    state_n = IDLE;
                    gnt_n   = 2'b00;
                end else begin
                    word_n = {word[WIDTH-2:0], bit_in};
                    cnt_n  = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state_n = DONE;
                end
            end
            DONE: begin
                if (|(ACK & GNT)) begin
                    state_n = IDLE;
                    gnt_n   = 2'b00;
                    last_n  = GNT[1];
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 2'b00;
            end
        endcase
    end

    assign VALID   = (state == DONE) ? GNT : 2'b00;
    assign DATA    = (state == DONE) ? word : '0;
    assign BUSY    = state != IDLE;
    assign RAND_EN = state == COLLECT;
endmodule

// File: tb/tb_rand_word_arb.sv
// tb_rand_word_arb: vector table, directed corner sequences and random traffic against a queue-based model
module tb_rand_word_arb;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         RAND_IN = 1'b0;
    logic [1:0]   REQ = 2'b00;
    logic [1:0]   ACK = 2'b00;
    logic         RAND_EN;
    logic         BUSY;
    logic [1:0]   GNT;
    logic [1:0]   VALID;
    logic [W-1:0] DATA;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    rand_word_arb #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .RAND_IN(RAND_IN), .RAND_EN(RAND_EN),
        .REQ(REQ), .GNT(GNT), .VALID(VALID), .ACK(ACK), .DATA(DATA), .BUSY(BUSY)
    );

    // transaction-level model: who owns the arbiter and the bits gathered so far
    int owner = -1;
    bit m_last = 1'b1;
    bit q[$];

    function automatic logic [W-1:0] m_data();
        logic [W-1:0] d = '0;
        foreach (q[i]) d = {d[W-2:0], q[i]};
        return d;
    endfunction

    task automatic model_step(input bit rst, input logic [1:0] req, input logic [1:0] ack, input bit rin);
        if (rst) begin
            owner = -1;
            q.delete();
            m_last = 1'b1;
        end else if (owner < 0) begin
            if (req != 2'b00) begin
                owner = (req == 2'b11) ? (m_last ? 0 : 1) : ((req == 2'b01) ? 0 : 1);
                q.delete();
            end
        end else if (q.size() < W) begin
            if (!req[owner]) begin
                owner = -1;
                q.delete();
            end else q.push_back(rin);
        end else if (ack[owner]) begin
            m_last = (owner == 1);
            owner = -1;
            q.delete();
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rst, input logic [1:0] req, input logic [1:0] ack, input bit rin);
        logic [1:0] mg;
        bit full;
        RESET = rst;
        REQ = req;
        ACK = ack;
        RAND_IN = rin;
        @(posedge CLK);
        model_step(rst, req, ack, rin);
        #1;
        mg = (owner >= 0) ? 2'(1 << owner) : 2'b00;
        full = (owner >= 0) && (q.size() == W);
        chk("model.gnt", 32'(GNT), 32'(mg));
        chk("model.valid", 32'(VALID), 32'(full ? mg : 2'b00));
        chk("model.data", 32'(DATA), 32'(full ? m_data() : '0));
        chk("model.busy", 32'(BUSY), 32'(owner >= 0));
        chk("model.rand_en", 32'(RAND_EN), 32'((owner >= 0) && !full));
    endtask

    task automatic want(input string tag, input logic [1:0] g, input logic [1:0] v, input logic [W-1:0] d, input bit b);
        chk({tag, ".gnt"}, 32'(GNT), 32'(g));
        chk({tag, ".valid"}, 32'(VALID), 32'(v));
        chk({tag, ".data"}, 32'(DATA), 32'(d));
        chk({tag, ".busy"}, 32'(BUSY), 32'(b));
    endtask

    typedef struct {
        bit           rst;
        logic [1:0]   req;
        logic [1:0]   ack;
        bit           rin;
        logic [1:0]   g;
        logic [1:0]   v;
        logic [W-1:0] d;
        bit           b;
    } vec_t;

    function automatic vec_t mkv(bit rst, logic [1:0] req, logic [1:0] ack, bit rin,
                                 logic [1:0] g, logic [1:0] v, logic [W-1:0] d, bit b);
        vec_t x;
        x.rst = rst; x.req = req; x.ack = ack; x.rin = rin;
        x.g = g; x.v = v; x.d = d; x.b = b;
        return x;
    endfunction

    vec_t tbl[12];

    initial begin
        logic [1:0] r;
        logic [1:0] a;
        bit pat[8];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // basic word assembly: bits 1,0,1,1,0,0,1,0 give 8'hB2
        tbl[0] = mkv(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 8'h00, 0);
        tbl[1] = mkv(0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 8'h00, 1);
        for (int i = 0; i < 7; i++)
            tbl[2+i] = mkv(0, 2'b01, 2'b00, pat[i], 2'b01, 2'b00, 8'h00, 1);
        tbl[9]  = mkv(0, 2'b01, 2'b00, pat[7], 2'b01, 2'b01, 8'hB2, 1);
        tbl[10] = mkv(0, 2'b01, 2'b01, 0, 2'b00, 2'b00, 8'h00, 0);
        tbl[11] = mkv(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].rst, tbl[i].req, tbl[i].ack, tbl[i].rin);
            want($sformatf("vec%0d", i), tbl[i].g, tbl[i].v, tbl[i].d, tbl[i].b);
        end

        // round-robin: tie after reset goes to 0, then alternates; no grant in the ACK cycle
        cyc(1, 2'b00, 2'b00, 0);
        cyc(0, 2'b11, 2'b00, 0);
        want("rr.first", 2'b01, 2'b00, 8'h00, 1);
        for (int i = 0; i < W; i++) cyc(0, 2'b11, 2'b00, 1);
        want("rr.done0", 2'b01, 2'b01, 8'hFF, 1);
        cyc(0, 2'b11, 2'b01, 0);
        want("rr.ackcyc", 2'b00, 2'b00, 8'h00, 0);
        cyc(0, 2'b11, 2'b00, 0);
        want("rr.second", 2'b10, 2'b00, 8'h00, 1);
        for (int i = 0; i < W; i++) cyc(0, 2'b11, 2'b00, 0);
        want("rr.done1", 2'b10, 2'b10, 8'h00, 1);
        cyc(0, 2'b11, 2'b10, 0);
        cyc(0, 2'b11, 2'b00, 0);
        want("rr.third", 2'b01, 2'b00, 8'h00, 1);

        // abort after 3 collect cycles; pointer unchanged so the next tie goes to 0
        cyc(1, 2'b00, 2'b00, 0);
        cyc(0, 2'b01, 2'b00, 0);
        for (int i = 0; i < 3; i++) cyc(0, 2'b01, 2'b00, 1);
        cyc(0, 2'b00, 2'b00, 1);
        want("abort.idle", 2'b00, 2'b00, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2'b00, 2'b00, 1);
            chk("abort.novalid", 32'(VALID), 32'(0));
        end
        cyc(0, 2'b11, 2'b00, 0);
        want("abort.tie", 2'b01, 2'b00, 8'h00, 1);

        // reset in the 5th collect cycle, then a full fresh word
        cyc(1, 2'b00, 2'b00, 0);
        cyc(0, 2'b01, 2'b00, 0);
        for (int i = 0; i < 4; i++) cyc(0, 2'b01, 2'b00, 1);
        cyc(1, 2'b01, 2'b00, 1);
        want("rst.mid", 2'b00, 2'b00, 8'h00, 0);
        chk("rst.rand_en", 32'(RAND_EN), 32'(0));
        cyc(0, 2'b01, 2'b00, 1);
        want("rst.regrant", 2'b01, 2'b00, 8'h00, 1);
        for (int i = 0; i < W - 1; i++) cyc(0, 2'b01, 2'b00, 1);
        chk("rst.early_valid", 32'(VALID), 32'(0));
        cyc(0, 2'b01, 2'b00, 1);
        want("rst.full", 2'b01, 2'b01, 8'hFF, 1);

        // VALID held without ACK, foreign ACK ignored, owner ACK completes
        cyc(1, 2'b00, 2'b00, 0);
        cyc(0, 2'b01, 2'b00, 0);
        for (int i = 0; i < W; i++) cyc(0, 2'b01, 2'b00, i[0]);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 2'b01, 2'b00, 0);
            want("hold", 2'b01, 2'b01, 8'h55, 1);
        end
        cyc(0, 2'b00, 2'b10, 0);
        want("hold.foreign_ack", 2'b01, 2'b01, 8'h55, 1);
        cyc(0, 2'b00, 2'b01, 0);
        want("hold.ack", 2'b00, 2'b00, 8'h00, 0);

        // random traffic against the model
        r = 2'b00;
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 2; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            a = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cyc($urandom_range(0, 299) == 0, r, a, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
